// File: rtl/minimig_bankmap_seq.sv
`default_nettype none
// ============================================================================
//  Module   : minimig_bankmap_seq
//  Purpose  : Registered Minimig memory bank mapper with chip-size config FSM.
//             Optional sticky unmapped-access flag: MINIMIG_BANKMAP_ERRFLAG_EN.
//  Revision : 1.0  initial release
// ============================================================================
module minimig_bankmap_seq #(
    parameter int CHIP_BANKS = 4,
    parameter int SLOW_BANKS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  as,
    input  logic                  cycle_end,
    input  logic [CHIP_BANKS-1:0] chip_sel,
    input  logic [SLOW_BANKS-1:0] slow_sel,
    input  logic                  kick,
    input  logic                  kick1mb,
    input  logic                  kick256kmirror,
    input  logic                  cart,
    input  logic                  cfg_req,
    input  logic [2:0]            cfg_in,
    output logic                  cfg_ack,
    output logic [2:0]            cfg_active,
    output logic [CHIP_BANKS-1:0] chip_bank,
    output logic                  slow_bank,
    output logic                  kick_bank,
    output logic                  mirror_bank,
    output logic                  busy,
    output logic                  err_unmapped
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_APPLY  = 2'd2;

    localparam logic [3:0] C_BANKS = 4'(CHIP_BANKS);
    localparam logic [2:0] C_MAX   = 3'(CHIP_BANKS - 1);

    logic [1:0]            r_state;
    logic [2:0]            r_cfg_active;
    logic                  r_pend_cfg;
    logic [2:0]            r_pend_val;
    logic                  r_pend_as;
    logic [CHIP_BANKS-1:0] r_chip;
    logic                  r_slow;
    logic                  r_kick;
    logic                  r_mirror;
    logic                  r_busy;
    logic                  r_ack;

    logic [3:0]            w_size;
    logic [3:0]            w_mask;
    logic                  w_pow2;
    logic [CHIP_BANKS-1:0] w_chip_map;
    logic                  w_slow;
    logic                  w_start;
    logic                  w_pend_cfg;
    logic [2:0]            w_pend_val;
    logic                  w_go_apply;
`ifdef MINIMIG_BANKMAP_ERRFLAG_EN
    logic                  w_unmapped;
    logic                  r_err;
`endif

    function automatic logic [2:0] clamp_cfg(input logic [2:0] v);
        return ({1'b0, v} >= C_BANKS) ? C_MAX : v;
    endfunction

    assign w_size = {1'b0, r_cfg_active} + 4'd1;
    assign w_mask = w_size - 4'd1;
    assign w_pow2 = ((w_size & w_mask) == 4'd0);
    assign w_slow = (|slow_sel) | kick1mb | cart;

    // Blocks beyond the configured size alias only when the size is a power of two.
    always_comb begin
        logic [3:0] idx;
        logic [3:0] tgt;
        logic       ok;
        w_chip_map = '0;
`ifdef MINIMIG_BANKMAP_ERRFLAG_EN
        w_unmapped = 1'b0;
`endif
        for (int i = 0; i < CHIP_BANKS; i++) begin
            idx = 4'(i);
            tgt = 4'd0;
            ok  = 1'b0;
            if (idx < w_size) begin
                tgt = idx;
                ok  = 1'b1;
            end else if (w_pow2) begin
                tgt = idx & w_mask;
                ok  = 1'b1;
            end
            if (chip_sel[i]) begin
                for (int j = 0; j < CHIP_BANKS; j++) begin
                    if (ok && (tgt == 4'(j))) begin
                        w_chip_map[j] = 1'b1;
                    end
                end
`ifdef MINIMIG_BANKMAP_ERRFLAG_EN
                if (!ok) begin
                    w_unmapped = 1'b1;
                end
`endif
            end
        end
    end

    assign w_start    = (r_state == S_IDLE) && (as || r_pend_as);
    assign w_pend_cfg = r_pend_cfg | cfg_req;
    assign w_pend_val = cfg_req ? cfg_in : r_pend_val;
    assign w_go_apply = ((r_state == S_IDLE) && !w_start && cfg_req) ||
                        ((r_state == S_ACCESS) && cycle_end && w_pend_cfg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cfg_active <= 3'd0;
            r_pend_cfg   <= 1'b0;
            r_pend_val   <= 3'd0;
            r_pend_as    <= 1'b0;
            r_chip       <= '0;
            r_slow       <= 1'b0;
            r_kick       <= 1'b0;
            r_mirror     <= 1'b0;
            r_busy       <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_ACCESS;
                        r_busy    <= 1'b1;
                        r_chip    <= w_chip_map;
                        r_slow    <= w_slow;
                        r_kick    <= kick;
                        r_mirror  <= kick256kmirror;
                        r_pend_as <= 1'b0;
                        if (cfg_req) begin
                            r_pend_cfg <= 1'b1;
                            r_pend_val <= cfg_in;
                        end
                    end else if (w_go_apply) begin
                        r_state      <= S_APPLY;
                        r_cfg_active <= clamp_cfg(cfg_in);
                        r_ack        <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (cycle_end) begin
                        r_chip     <= '0;
                        r_slow     <= 1'b0;
                        r_kick     <= 1'b0;
                        r_mirror   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_pend_cfg <= 1'b0;
                        if (w_go_apply) begin
                            r_state      <= S_APPLY;
                            r_cfg_active <= clamp_cfg(w_pend_val);
                            r_ack        <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (cfg_req) begin
                        r_pend_cfg <= 1'b1;
                        r_pend_val <= cfg_in;
                    end
                end
                S_APPLY: begin
                    r_state <= S_IDLE;
                    if (as) begin
                        r_pend_as <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MINIMIG_BANKMAP_ERRFLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_go_apply) begin
            r_err <= 1'b0;
        end else if (w_start && w_unmapped) begin
            r_err <= 1'b1;
        end
    end
    assign err_unmapped = r_err;
`else
    assign err_unmapped = 1'b0;
`endif

    assign cfg_ack     = r_ack;
    assign cfg_active  = r_cfg_active;
    assign chip_bank   = r_chip;
    assign slow_bank   = r_slow;
    assign kick_bank   = r_kick;
    assign mirror_bank = r_mirror;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_minimig_bankmap_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_minimig_bankmap_seq
//  Purpose  : Scoreboard bench for minimig_bankmap_seq (default 4 chip / 3 slow).
//  Revision : 1.0  initial release
// ============================================================================
module tb_minimig_bankmap_seq;

`ifdef MINIMIG_BANKMAP_ERRFLAG_EN
    localparam bit ERRF = 1'b1;
`else
    localparam bit ERRF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       as = 1'b0;
    logic       cycle_end = 1'b0;
    logic [3:0] chip_sel = '0;
    logic [2:0] slow_sel = '0;
    logic       kick = 1'b0;
    logic       kick1mb = 1'b0;
    logic       kick256kmirror = 1'b0;
    logic       cart = 1'b0;
    logic       cfg_req = 1'b0;
    logic [2:0] cfg_in = '0;
    logic       cfg_ack;
    logic [2:0] cfg_active;
    logic [3:0] chip_bank;
    logic       slow_bank;
    logic       kick_bank;
    logic       mirror_bank;
    logic       busy;
    logic       err_unmapped;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_q[$];
    logic [12:0] ev;
    logic [12:0] got;
    logic [2:0]  m_act = 3'd0;
    bit          m_err = 1'b0;

    minimig_bankmap_seq #(.CHIP_BANKS(4), .SLOW_BANKS(3)) dut (
        .clk(clk), .reset(reset), .as(as), .cycle_end(cycle_end),
        .chip_sel(chip_sel), .slow_sel(slow_sel), .kick(kick), .kick1mb(kick1mb),
        .kick256kmirror(kick256kmirror), .cart(cart), .cfg_req(cfg_req), .cfg_in(cfg_in),
        .cfg_ack(cfg_ack), .cfg_active(cfg_active), .chip_bank(chip_bank),
        .slow_bank(slow_bank), .kick_bank(kick_bank), .mirror_bank(mirror_bank),
        .busy(busy), .err_unmapped(err_unmapped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Field order: chip[12:9] slow kick mirror busy act[4:2] ack err
    function automatic logic [12:0] mk(input logic [3:0] c, input logic s, k, m, b,
                                       input logic [2:0] a, input logic ak, e);
        return {c, s, k, m, b, a, ak, e};
    endfunction

    function automatic logic [12:0] obs();
        return {chip_bank, slow_bank, kick_bank, mirror_bank, busy, cfg_active, cfg_ack, err_unmapped};
    endfunction

    // Reference mapping: bit 4 flags an unmapped access.
    function automatic logic [4:0] model_map(input int c, input int i);
        int s;
        s = c + 1;
        if (i < s) return 5'(1 << i);
        if (s == 1 || s == 2 || s == 4 || s == 8) return 5'(1 << (i % s));
        return 5'b10000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        as = 1'b0;
        cycle_end = 1'b0;
        cfg_req = 1'b0;
    endtask

    task automatic clear_sels();
        chip_sel = '0; slow_sel = '0; kick = 0; kick1mb = 0; kick256kmirror = 0; cart = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd0, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, ev); end
        reset = 1'b0;
        m_act = 3'd0; m_err = 1'b0;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd0, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL reset_release got=%h exp=%h", got, ev); end
    endtask

    task automatic do_cfg(input logic [2:0] c, input string nm);
        cfg_req = 1'b1;
        cfg_in = c;
        m_act = (int'(c) >= 4) ? 3'd3 : c;
        m_err = 1'b0;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, m_act, 1, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL %s_ack got=%h exp=%h", nm, got, ev); end
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, m_act, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL %s_after got=%h exp=%h", nm, got, ev); end
    endtask

    task automatic access(input logic [3:0] cs, input logic [2:0] ss, input logic k, k1, km, ct,
                          input logic [3:0] exp_chip, input bit unm, input string nm);
        as = 1'b1;
        chip_sel = cs; slow_sel = ss; kick = k; kick1mb = k1; kick256kmirror = km; cart = ct;
        if (unm && ERRF) m_err = 1'b1;
        exp_q.push_back(mk(exp_chip, (|ss) | k1 | ct, k, km, 1, m_act, 0, m_err));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL %s_start got=%h exp=%h", nm, got, ev); end
        cycle_end = 1'b1;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, m_act, 0, m_err));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL %s_end got=%h exp=%h", nm, got, ev); end
    endtask

    task automatic test_map_pow2();
        do_cfg(3'd1, "pow2_cfg");
        access(4'b1000, 3'b000, 0, 0, 0, 0, 4'b0010, 0, "pow2_s2");
    endtask

    task automatic test_map_unmapped();
        do_cfg(3'd2, "unm_cfg");
        access(4'b1000, 3'b010, 1, 0, 1, 0, 4'b0000, 1, "unm_s3");
        // Flag must clear when the next configuration is applied.
        do_cfg(3'd2, "unm_clear");
    endtask

    task automatic test_map_sweep();
        logic [4:0] r;
        logic [5:0] rnd;
        for (int c = 0; c < 4; c++) begin
            do_cfg(3'(c), "sweep_cfg");
            for (int i = 0; i < 4; i++) begin
                r = model_map(c, i);
                rnd = 6'($urandom);
                access(4'(1 << i), rnd[2:0], rnd[3], rnd[4], rnd[5], rnd[0] ^ rnd[5],
                       r[3:0], r[4], $sformatf("sweep_c%0d_i%0d", c, i));
            end
        end
    endtask

    task automatic test_cfg_during_access();
        clear_sels();
        do_cfg(3'd0, "pend_cfg0");
        as = 1'b1; chip_sel = 4'b0001;
        exp_q.push_back(mk(4'b0001, 0, 0, 0, 1, 3'd0, 0, m_err));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL pend_start got=%h exp=%h", got, ev); end
        cfg_req = 1'b1; cfg_in = 3'd1;
        exp_q.push_back(mk(4'b0001, 0, 0, 0, 1, 3'd0, 0, m_err));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL pend_req1 got=%h exp=%h", got, ev); end
        cfg_req = 1'b1; cfg_in = 3'd3;
        exp_q.push_back(mk(4'b0001, 0, 0, 0, 1, 3'd0, 0, m_err));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL pend_req3 got=%h exp=%h", got, ev); end
        cycle_end = 1'b1;
        m_act = 3'd3; m_err = 1'b0;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd3, 1, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL pend_apply got=%h exp=%h", got, ev); end
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL pend_idle got=%h exp=%h", got, ev); end
    endtask

    task automatic test_clamp();
        do_cfg(3'd0, "clamp_pre");
        do_cfg(3'd7, "clamp7");
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL clamp_single_ack got=%h exp=%h", got, ev); end
    endtask

    task automatic test_reset_mid();
        do_cfg(3'd2, "rst_cfg");
        as = 1'b1; chip_sel = 4'b0001; kick = 1'b1;
        exp_q.push_back(mk(4'b0001, 0, 1, 0, 1, 3'd2, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL rstmid_start got=%h exp=%h", got, ev); end
        cfg_req = 1'b1; cfg_in = 3'd1;
        #2;
        reset = 1'b1;
        m_act = 3'd0; m_err = 1'b0;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd0, 0, 0));
        #1;
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL rstmid_async got=%h exp=%h", got, ev); end
        cfg_req = 1'b0;
        #1;
        reset = 1'b0;
        clear_sels();
        for (int n = 0; n < 2; n++) begin
            exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd0, 0, 0));
            tick();
            ev = exp_q.pop_front(); got = obs(); checks++;
            if (got !== ev) begin errors++; $display("FAIL rstmid_noack%0d got=%h exp=%h", n, got, ev); end
        end
    endtask

    task automatic test_as_cfg_together();
        // cfg_active is 0 (one block), so block 2 aliases onto block 0.
        as = 1'b1; cfg_req = 1'b1; cfg_in = 3'd2; chip_sel = 4'b0100;
        exp_q.push_back(mk(4'b0001, 0, 0, 0, 1, 3'd0, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL together_access got=%h exp=%h", got, ev); end
        cycle_end = 1'b1;
        m_act = 3'd2;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd2, 1, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL together_apply got=%h exp=%h", got, ev); end
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd2, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL together_idle got=%h exp=%h", got, ev); end
    endtask

    task automatic test_as_in_apply();
        clear_sels();
        cfg_req = 1'b1; cfg_in = 3'd3;
        m_act = 3'd3; m_err = 1'b0;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd3, 1, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL asapply_ack got=%h exp=%h", got, ev); end
        as = 1'b1; chip_sel = 4'b0010; kick = 1'b1;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL asapply_held got=%h exp=%h", got, ev); end
        exp_q.push_back(mk(4'b0010, 0, 1, 0, 1, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL asapply_start got=%h exp=%h", got, ev); end
        cycle_end = 1'b1;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL asapply_end got=%h exp=%h", got, ev); end
    endtask

    task automatic test_back_to_back();
        clear_sels();
        as = 1'b1; chip_sel = 4'b0001; cart = 1'b1;
        exp_q.push_back(mk(4'b0001, 1, 0, 0, 1, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL b2b_first got=%h exp=%h", got, ev); end
        as = 1'b1; chip_sel = 4'b0100; cart = 1'b0; kick256kmirror = 1'b1;
        exp_q.push_back(mk(4'b0001, 1, 0, 0, 1, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL b2b_as_ignored got=%h exp=%h", got, ev); end
        as = 1'b1; cycle_end = 1'b1;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL b2b_end_only got=%h exp=%h", got, ev); end
        as = 1'b1;
        exp_q.push_back(mk(4'b0100, 0, 0, 1, 1, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL b2b_second got=%h exp=%h", got, ev); end
        cycle_end = 1'b1;
        exp_q.push_back(mk(4'h0, 0, 0, 0, 0, 3'd3, 0, 0));
        tick();
        ev = exp_q.pop_front(); got = obs(); checks++;
        if (got !== ev) begin errors++; $display("FAIL b2b_idle got=%h exp=%h", got, ev); end
    endtask

    initial begin
        test_reset();
        test_map_pow2();
        test_map_unmapped();
        test_map_sweep();
        test_cfg_during_access();
        test_clamp();
        test_reset_mid();
        test_as_cfg_together();
        test_as_in_apply();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/minimig_bankmap_seq.md
MINIMIG_BANKMAP_SEQ -- requirements
Module: minimig_bankmap_seq

Interface
REQ-001 The block SHALL have parameter CHIP_BANKS, default 4, number of 512 KB chip RAM blocks (legal 1..8).
REQ-002 The block SHALL have parameter SLOW_BANKS, default 3, number of 512 KB slow RAM blocks (legal 1..8).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with the following ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous active-high reset
- as  in  1  access strobe; one-cycle pulse starting an access
- cycle_end  in  1  one-cycle pulse ending the current access
- chip_sel  in  CHIP_BANKS  per-block chip RAM decode
- slow_sel  in  SLOW_BANKS  per-block slow RAM decode
- kick, kick1mb, kick256kmirror, cart  in  1 each  ROM / upper-kick / mirror / cartridge decodes
- cfg_req  in  1  request to load cfg_in
- cfg_in  in  3  requested chip size minus one, in 512 KB units
- cfg_ack  out  1  one-cycle pulse when cfg_in is applied
- cfg_active  out  3  applied chip size minus one
- chip_bank  out  CHIP_BANKS  one-hot physical chip block
- slow_bank, kick_bank, mirror_bank  out  1 each  registered slow/upper-kick/cart, kick, and mirror selects
- busy  out  1  access in progress
- err_unmapped  out  1  sticky unmapped-chip-access flag (see Configuration)

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, and APPLY.
REQ-005 IDLE→ACCESS on as: latch all bank outputs from the inputs at that edge; outputs valid the next cycle; busy=1.
REQ-006 ACCESS→IDLE on cycle_end: clear all bank outputs; busy=0 the next cycle.
REQ-007 as during ACCESS SHALL be ignored; as and cycle_end together in ACCESS SHALL end the access only.
REQ-008 cfg_req in IDLE with as low→APPLY: cfg_active<=clamped cfg_in; cfg_ack=1 for that APPLY cycle; APPLY→IDLE unconditionally.
REQ-009 cfg_req in ACCESS SHALL latch cfg_in as pending; APPLY SHALL be entered the cycle after cycle_end; a later cfg_req before then SHALL overwrite pending.
REQ-010 cfg_req and as together in IDLE: the access wins; the request becomes pending per REQ-009.
REQ-011 as in APPLY SHALL be held as a pending access and started in the following IDLE cycle.
REQ-012 Clamping: cfg_in ≥ CHIP_BANKS SHALL load CHIP_BANKS-1.
REQ-013 Mapping, with size S=cfg_active+1, for each chip_sel[i]:
- i<S: chip_bank[i]
- i≥S and S is a power of two: chip_bank[i mod S]
- otherwise: unmapped; no chip_bank bit set
REQ-014 The other registered selects SHALL be:
- slow_bank = OR(slow_sel) | kick1mb | cart
- kick_bank = kick
- mirror_bank = kick256kmirror
REQ-015 Decode and mapping at the as edge SHALL use cfg_active as held before that edge.

Reset
REQ-016 On reset, the FSM SHALL enter IDLE and these outputs SHALL be 0: bank outputs, busy, cfg_ack, err_unmapped, and pending flags.
REQ-017 On reset, cfg_active SHALL be 3'd0 (0.5 MB).
REQ-018 Reset asserted mid-access SHALL abort the access with no cfg_ack.

Configuration
REQ-019 With macro MINIMIG_BANKMAP_ERRFLAG_EN defined, err_unmapped SHALL set on a latched unmapped chip access and clear only on APPLY or reset.
REQ-020 Without MINIMIG_BANKMAP_ERRFLAG_EN, err_unmapped SHALL be tied to 0 and no flag register SHALL be built.

Verification
REQ-021 The bench SHALL cover these scenarios:
- S=2 (cfg 1), as with chip_sel=4'b1000 → chip_bank=4'b0010 the next cycle, busy=1.
- S=3 (cfg 2), as with chip_sel=4'b1000 → chip_bank=0; err_unmapped=1 with the macro, 0 without.
- cfg_req cfg_in=3 during ACCESS → cfg_active stays 0 until cycle_end; cfg_ack one cycle after; cfg_active=3.
- cfg_req cfg_in=7 with CHIP_BANKS=4 → cfg_active=3 and cfg_ack pulses once.
- reset mid-ACCESS → all outputs 0 and cfg_active=0 immediately, no cfg_ack.
- as and cfg_req together in IDLE → access latched first; APPLY follows cycle_end.
